// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 8-digit seven-segment display into remainder/quotient words.
// Each digit must be stable for STABLE_CYCLES samples before it is accepted.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [7:0]  an,
    output logic [15:0] remainder,
    output logic [15:0] quotient,
    output logic        frame_valid,
    output logic        seg_err,
    output logic [7:0]  err_count
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);

    typedef enum logic {StSettle, StHeld} state_e;

    state_e      state_q, state_d;
    logic [6:0]  s_seg_q;
    logic [7:0]  s_an_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic [7:0]  errc_q, errc_d;

    logic        sample_diff;
    logic        accept;
    logic        seg_ok;
    logic [3:0]  nib;
    logic [7:0]  an_low;
    logic        an_onehot;
    logic [2:0]  idx;
    logic        frame_done;
    logic [7:0]  mask_base;

    always_comb begin
        seg_ok = 1'b1;
        nib    = 4'h0;
        unique case (s_seg_q)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0011000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    seg_ok = 1'b0;
        endcase
    end

    always_comb begin
        sample_diff = ({an, seg} != {s_an_q, s_seg_q});
        if (sample_diff) begin
            cnt_d = 8'd1;
        end else if (cnt_q < CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // cnt_d can only reach CntMax (>= 2) when the sample is unchanged, so S is the dwell value
        accept = (state_q == StSettle) && (cnt_d == CntMax);

        if (sample_diff) begin
            state_d = StSettle;
        end else if (accept) begin
            state_d = StHeld;
        end else begin
            state_d = state_q;
        end

        an_low    = ~s_an_q;
        an_onehot = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
        idx       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) idx = 3'(i);
        end

        frame_done = (mask_q == 8'hFF);
        // A digit accepted on the clearing edge starts the next frame
        mask_base  = frame_done ? 8'h00 : mask_q;
        mask_d     = mask_base;
        shadow_d   = shadow_q;
        if (accept && an_onehot && seg_ok) begin
            shadow_d[{idx, 2'b00} +: 4] = nib;
            mask_d = mask_base | an_low;
        end

        err_d  = accept && an_onehot && !seg_ok;
        errc_d = (err_d && (errc_q != 8'hFF)) ? errc_q + 8'd1 : errc_q;

        rem_d = frame_done ? shadow_q[31:16] : rem_q;
        quo_d = frame_done ? shadow_q[15:0] : quo_q;
        fv_d  = frame_done;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_an_q   <= 8'hFF;
            s_seg_q  <= 7'h7F;
            cnt_q    <= 8'd0;
            state_q  <= StSettle;
            shadow_q <= 32'h0;
            mask_q   <= 8'h00;
            rem_q    <= 16'h0;
            quo_q    <= 16'h0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= 8'd0;
        end else begin
            s_an_q   <= an;
            s_seg_q  <= seg;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
        end
    end

    assign remainder   = rem_q;
    assign quotient    = quo_q;
    assign frame_valid = fv_q;
    assign seg_err     = err_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture; expected frames queue up as digits are driven
// and are popped when frame_valid fires.
module tb_seven_seg_capture;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [15:0] remainder;
    logic [15:0] quotient;
    logic        frame_valid;
    logic        seg_err;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int fcount  = 0;
    int secnt   = 0;
    logic [31:0] exp_q [$];

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .remainder  (remainder),
        .quotient   (quotient),
        .frame_valid(frame_valid),
        .seg_err    (seg_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] r, input logic [15:0] q,
                                          input int idx);
        return (idx < 4) ? q[idx*4 +: 4] : r[(idx-4)*4 +: 4];
    endfunction

    task automatic drive_digit(input int idx, input logic [3:0] v, input int cyc);
        an  = ~(8'(1) << idx);
        seg = SEG_TBL[v];
        hold(cyc);
    endtask

    task automatic drive_frame(input logic [15:0] r, input logic [15:0] q, input int cyc);
        for (int i = 0; i < 8; i++) drive_digit(i, nib_of(r, q, i), cyc);
    endtask

    task automatic idle(input int cyc);
        an  = 8'hFF;
        seg = 7'h7F;
        hold(cyc);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (frame_valid === 1'b1) begin
            fcount++;
            if (exp_q.size() == 0) begin
                chk("frame_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("frame_rem", 32'(remainder), 32'(e[31:16]));
                chk("frame_quo", 32'(quotient), 32'(e[15:0]));
            end
        end
        if (seg_err === 1'b1) secnt++;
    end

    initial begin
        int base;
        rst = 1'b0;
        an  = 8'hFF;
        seg = 7'h7F;
        hold(2);
        rst = 1'b1;
        chk("rst_rem", 32'(remainder), 32'h0);
        chk("rst_quo", 32'(quotient), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_segerr", 32'(seg_err), 32'h0);
        chk("rst_errcnt", 32'(err_count), 32'h0);

        // Dwells too short to accept
        idle(6);
        for (int i = 0; i < 8; i++) drive_digit(i, 4'(i + 3), 3);
        idle(8);
        chk("short_fcount", 32'(fcount), 32'd0);
        chk("short_rem", 32'(remainder), 32'h0);
        chk("short_quo", 32'(quotient), 32'h0);

        // Normal scan with latency check on the final digit
        exp_q.push_back({16'h1234, 16'h00AB});
        for (int i = 0; i < 7; i++) drive_digit(i, nib_of(16'h1234, 16'h00AB, i), 8);
        an  = 8'h7F;
        seg = SEG_TBL[1];
        hold(4);
        chk("lat_fv_early", 32'(frame_valid), 32'd0);
        hold(1);
        chk("lat_fv_on", 32'(frame_valid), 32'd1);
        hold(1);
        chk("lat_fv_pulse", 32'(frame_valid), 32'd0);
        hold(2);
        idle(4);
        chk("scan_fcount", 32'(fcount), 32'd1);
        chk("scan_rem_hold", 32'(remainder), 32'h1234);
        chk("scan_quo_hold", 32'(quotient), 32'h00AB);

        // Non one-hot anodes are ignored
        an = 8'b11001111; seg = SEG_TBL[5]; hold(8);
        an = 8'b11001111; seg = 7'h7F;      hold(8);
        idle(8);
        chk("badan_errcnt", 32'(err_count), 32'd0);
        chk("badan_segerr", 32'(secnt), 32'd0);

        // Invalid segment on digit 2 must not fill that slot
        exp_q.push_back({16'h5678, 16'hCDEF});
        for (int i = 0; i < 8; i++) begin
            if (i != 2) drive_digit(i, nib_of(16'h5678, 16'hCDEF, i), 8);
        end
        an = 8'b11111011; seg = 7'h7F; hold(8);
        chk("inval_segerr", 32'(secnt), 32'd1);
        chk("inval_errcnt", 32'(err_count), 32'd1);
        idle(4);
        chk("inval_nofill", 32'(fcount), 32'd1);
        drive_digit(2, 4'hD, 8);
        idle(4);
        chk("inval_fill", 32'(fcount), 32'd2);

        // Reset mid-frame discards the partial mask
        for (int i = 0; i < 5; i++) drive_digit(i, 4'(9 - i), 8);
        an = 8'hFF; seg = 7'h7F;
        rst = 1'b0;
        hold(1);
        rst = 1'b1;
        chk("midrst_errcnt", 32'(err_count), 32'd0);
        chk("midrst_rem", 32'(remainder), 32'h0);
        exp_q.push_back({16'hA5C3, 16'h1E07});
        for (int i = 5; i < 8; i++) drive_digit(i, nib_of(16'hA5C3, 16'h1E07, i), 8);
        idle(6);
        chk("midrst_partial", 32'(fcount), 32'd2);
        for (int i = 0; i < 5; i++) drive_digit(i, nib_of(16'hA5C3, 16'h1E07, i), 8);
        idle(8);
        chk("midrst_full", 32'(fcount), 32'd3);

        // Back-to-back frames
        exp_q.push_back({16'hFFFF, 16'hFFFF});
        exp_q.push_back({16'h0000, 16'h0000});
        drive_frame(16'hFFFF, 16'hFFFF, 8);
        drive_frame(16'h0000, 16'h0000, 8);
        idle(8);
        chk("b2b_fcount", 32'(fcount), 32'd5);
        chk("b2b_rem", 32'(remainder), 32'h0);
        chk("b2b_quo", 32'(quotient), 32'h0);

        // Error counter saturation
        base = secnt;
        for (int k = 0; k < 300; k++) begin
            an  = (k % 2 == 0) ? 8'hFE : 8'hFD;
            seg = 7'h7F;
            hold(4);
        end
        idle(4);
        chk("sat_errcnt", 32'(err_count), 32'd255);
        chk("sat_pulses", 32'(secnt - base), 32'd300);
        chk("sat_fcount", 32'(fcount), 32'd5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
